// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// mult_div_unit_if : operand/result bundle between the EX stage and the MDU
// Revision 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [1:0]           op;
   logic [WIDTH-1:0]     rs;
   logic [WIDTH-1:0]     rt;
   logic                 flush;
   logic                 busy;
   logic                 RegWrite;
   logic [2*WIDTH-1:0]   WriteData;
   logic                 div_by_zero;

   modport master (
      output start, op, rs, rt, flush,
      input  busy, RegWrite, WriteData, div_by_zero
   );

   modport slave (
      input  start, op, rs, rt, flush,
      output busy, RegWrite, WriteData, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative radix-2 MULT/MULTU/DIV/DIVU producing {HI,LO}
// MDU_SIGNED_EN : when defined, op[0] selects signed MULT/DIV
// Revision 1.0 - initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  wire              clk,
   input  wire              rst,
   mult_div_unit_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MDU_SIGNED_EN
   localparam bit C_SIGNED_EN = 1'b1;
`else
   localparam bit C_SIGNED_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   wd_q, wd_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_hi_q, neg_hi_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 dbz_q, dbz_d;

   logic                 w_signed;
   logic                 w_rs_neg, w_rt_neg;
   logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
   logic [WIDTH:0]       w_sum, w_shift, w_diff;
   logic [WIDTH-1:0]     w_hi, w_lo;
   logic [2*WIDTH-1:0]   w_fixed;

   assign w_signed = bus.op[0] & C_SIGNED_EN;
   assign w_rs_neg = w_signed & bus.rs[WIDTH-1];
   assign w_rt_neg = w_signed & bus.rt[WIDTH-1];
   assign w_rs_mag = w_rs_neg ? -bus.rs : bus.rs;
   assign w_rt_mag = w_rt_neg ? -bus.rt : bus.rt;

   // acc holds {HI,LO}: product bits for multiply, {remainder,quotient} for divide
   assign w_hi    = acc_q[2*WIDTH-1:WIDTH];
   assign w_lo    = acc_q[WIDTH-1:0];
   assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_q} : '0);
   assign w_shift = {w_hi, w_lo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, b_q};

   always_comb begin
      w_fixed = acc_q;
      if (is_div_q) begin
         w_fixed[2*WIDTH-1:WIDTH] = neg_hi_q ? -w_hi : w_hi;
         w_fixed[WIDTH-1:0]       = neg_lo_q ? -w_lo : w_lo;
      end else if (neg_lo_q) begin
         w_fixed = -acc_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      wd_d     = wd_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_hi_d = neg_hi_q;
      neg_lo_d = neg_lo_q;
      dbz_d    = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               if (bus.op[1] && (bus.rt == '0)) begin
                  wd_d    = {bus.rs, {WIDTH{1'b1}}};
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  is_div_d = bus.op[1];
                  neg_lo_d = w_rs_neg ^ w_rt_neg;
                  neg_hi_d = w_rs_neg;
                  acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? w_rs_mag : w_rt_mag)};
                  b_d      = bus.op[1] ? w_rt_mag : w_rs_mag;
                  cnt_d    = CNT_W'(WIDTH);
                  dbz_d    = 1'b0;
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               if (!is_div_q)
                  acc_d = {w_sum, w_lo[WIDTH-1:1]};
               else if (w_diff[WIDTH])
                  acc_d = {w_shift[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
               else
                  acc_d = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1))
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               wd_d    = w_fixed;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         wd_q     <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_hi_q <= 1'b0;
         neg_lo_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         wd_q     <= wd_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_hi_q <= neg_hi_d;
         neg_lo_q <= neg_lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.RegWrite    = (state_q == S_DONE);
   assign bus.WriteData   = wd_q;
   assign bus.div_by_zero = dbz_q & (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : directed vectors, queue scoreboard with separate monitor
// Revision 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
   typedef struct {
      logic [63:0] wd;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];

   mult_div_unit_if #(.WIDTH(32)) bus ();
   mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: every RegWrite must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst && bus.RegWrite) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_regwrite: got WriteData 0x%0h with no pending op (t=%0t)",
                     bus.WriteData, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("WriteData", bus.WriteData, e.wd);
            check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            check("regwrite_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Drives one start at a negedge; returns at the negedge of cycle 1
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] wd, input logic dbz, input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      e.wd = wd; e.dbz = dbz; e.cyc = cyc + 1 + lat;
      if (push) sb.push_back(e);
      bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (!bus.busy && !bus.RegWrite) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL wait_idle: busy still %0b after 100 cycles, expected 0", bus.busy);
      end
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] wd, input logic dbz, input int lat);
      issue(op, a, b, wd, dbz, lat, 1'b1);
      wait_idle();
   endtask

   initial begin
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.rs = '0; bus.rt = '0;
      #12;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_regwrite", 64'(bus.RegWrite), 64'd0);
      check("reset_writedata", bus.WriteData, 64'd0);
      check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33);
`ifdef MDU_SIGNED_EN
      run(2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33);
      run(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 1'b0, 33);
      run(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33);
`else
      run(2'b01, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 1'b0, 33);
      run(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'hFFFF_FFFB_0000_0006, 1'b0, 33);
      run(2'b11, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 1'b0, 33);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 33);
`endif
      run(2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 33);

      // Divide by zero: single-cycle result, idle again in cycle 2
      issue(2'b10, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 0, 1'b1);
      @(negedge clk);
      check("dbz_busy_cycle2", 64'(bus.busy), 64'd0);
      run(2'b11, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b1, 0);

      // Second start while busy is dropped
      issue(2'b00, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0, 33, 1'b1);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.rs = 32'd50; bus.rt = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // Flush at cycle 10 cancels without a write
      issue(2'b00, 32'd9, 32'd9, 64'd0, 1'b0, 0, 1'b0);
      repeat (8) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", 64'(bus.busy), 64'd0);
      repeat (40) @(negedge clk);
      check("flush_wd_kept", bus.WriteData, 64'h0000_0000_0000_000C);

      // Flush together with start in IDLE wins
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.rs = 32'd2; bus.rt = 32'd2;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_start_idle", 64'(bus.busy), 64'd0);

      // Asynchronous reset mid-divide
      issue(2'b11, 32'd1000, 32'd3, 64'd0, 1'b0, 0, 1'b0);
      repeat (18) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_regwrite", 64'(bus.RegWrite), 64'd0);
      check("arst_writedata", bus.WriteData, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run(2'b10, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 1'b0, 33);

      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d results pending, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
